serial_adder: RTL and testbench

- Parametrised multi-bit adder that computes a WIDTH-bit sum digit-serially, DIGIT bits per clock, starting at the LSB.
- Successor to the single-bit combinational half adder. Adds carry-in, carry-out, signed overflow, configurable width and digit size, and valid/ready handshakes on both sides.
- Sits in the arithmetic datapath where area matters more than throughput.

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB first,
// producing sum, unsigned carry-out and two's-complement overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last_digit;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE and never while rst is high; out_valid is high only
  // in DONE, and sum/cout/ovf stay frozen until the edge where out_ready is seen high.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    dsum       = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit's top bit, recovered from its sum bit and operand bits.
    msb_cin    = dsum[DIGIT-1] ^ a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1];
    last_digit = (cnt_q == CW'(N - 1));

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = dsum[DIGIT];
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five instances (8/1, 8/4, 4/1, 4/2, 4/4) share operands,
// clock and reset; each has its own handshake signals.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic       in_valid  [5];
  logic       out_ready [5];
  logic       in_ready  [5];
  logic       out_valid [5];
  logic [7:0] sum_o     [5];
  logic       cout_o    [5];
  logic       ovf_o     [5];
  logic [3:0] sum4_2, sum4_3, sum4_4;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_8d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_8d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u_4d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum4_2), .cout(cout_o[2]), .ovf(ovf_o[2]));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_4d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .sum(sum4_3), .cout(cout_o[3]), .ovf(ovf_o[3]));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u_4d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid[4]), .out_ready(out_ready[4]),
    .sum(sum4_4), .cout(cout_o[4]), .ovf(ovf_o[4]));

  assign sum_o[2] = {4'b0, sum4_2};
  assign sum_o[3] = {4'b0, sum4_3};
  assign sum_o[4] = {4'b0, sum4_4};

  function automatic int w_of(input int d);
    return (d < 2) ? 8 : 4;
  endfunction

  function automatic int n_of(input int d);
    case (d)
      0: return 8;
      1: return 2;
      2: return 4;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer addition, overflow from operand/result sign bits.
  function automatic logic [9:0] ref_model(input int w, input logic [7:0] av, bv,
                                           input logic cv);
    int mask, aa, bb, full, ss;
    logic co, ov;
    mask = (1 << w) - 1;
    aa   = int'(av) & mask;
    bb   = int'(bv) & mask;
    full = aa + bb + int'(cv);
    ss   = full & mask;
    co   = ((full >> w) & 1) == 1;
    ov   = (((aa >> (w - 1)) & 1) == ((bb >> (w - 1)) & 1)) &&
           (((ss >> (w - 1)) & 1) != ((aa >> (w - 1)) & 1));
    return {ov, co, 8'(ss)};
  endfunction

  task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input int stall);
    logic [9:0] exp_v;
    int cnt;
    exp_v = ref_model(w_of(d), av, bv, cv);
    cnt = 0;
    while (!in_ready[d] && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    nvec++;
    if (in_ready[d] !== 1'b1) begin
      nfail++;
      $display("FAIL in_ready_wait dut%0d: in_ready=%b required 1", d, in_ready[d]);
    end
    a = av; b = bv; cin = cv; in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    cnt = 0;
    while (!out_valid[d] && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    nvec++;
    if (cnt !== n_of(d) || out_valid[d] !== 1'b1) begin
      nfail++;
      $display("FAIL latency dut%0d: %0d cycles (out_valid=%b) required %0d",
               d, cnt, out_valid[d], n_of(d));
    end
    for (int i = 0; i <= stall; i++) begin
      nvec++;
      if ({ovf_o[d], cout_o[d], sum_o[d]} !== exp_v || in_ready[d] !== 1'b0 ||
          out_valid[d] !== 1'b1) begin
        nfail++;
        $display("FAIL result dut%0d %h+%h+%b: ovf/cout/sum=%b/%b/%h in_ready=%b out_valid=%b required %b/%b/%h 0 1",
                 d, av, bv, cv, ovf_o[d], cout_o[d], sum_o[d], in_ready[d], out_valid[d],
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
      if (i < stall) @(negedge clk);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    nvec++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      nfail++;
      $display("FAIL release dut%0d: out_valid=%b in_ready=%b required 0 1",
               d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    for (int d = 0; d < 5; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || sum_o[d] !== 8'h00 ||
          cout_o[d] !== 1'b0 || ovf_o[d] !== 1'b0) begin
        nfail++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 0 0 00 0 0",
                 d, in_ready[d], out_valid[d], sum_o[d], cout_o[d], ovf_o[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (in_ready[d] !== 1'b1) begin
        nfail++;
        $display("FAIL post_reset_ready dut%0d: in_ready=%b required 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_directed();
    run_op(0, 8'h00, 8'h00, 1'b0, 0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1);
    run_op(0, 8'h7F, 8'h00, 1'b1, 0);
    run_op(1, 8'h80, 8'h80, 1'b0, 0);
    run_op(1, 8'hFF, 8'hFF, 1'b1, 2);
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_v;
    int cnt;
    exp_v = ref_model(8, 8'h5A, 8'h3C, 1'b1);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    cnt = 0;
    while (!out_valid[0] && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
          {ovf_o[0], cout_o[0], sum_o[0]} !== exp_v) begin
        nfail++;
        $display("FAIL backpressure cyc%0d: out_valid=%b in_ready=%b ovf/cout/sum=%b/%b/%h required 1 0 %b/%b/%h",
                 i, out_valid[0], in_ready[0], ovf_o[0], cout_o[0], sum_o[0],
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
      a = 8'($urandom); b = 8'($urandom); in_valid[0] = 1'($urandom);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    nvec++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      nfail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid[0], in_ready[0]);
    end
    repeat (10) @(negedge clk);
    nvec++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      nfail++;
      $display("FAIL bp_no_capture: out_valid=%b in_ready=%b required 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 8'hA5; b = 8'h5A; cin = 1'b1; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (in_ready[d] !== 1'b0) begin
        nfail++;
        $display("FAIL ready_during_rst dut%0d: in_ready=%b required 0", d, in_ready[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum_o[0] !== 8'h00) begin
      nfail++;
      $display("FAIL after_mid_rst: in_ready=%b out_valid=%b sum=%h required 1 0 00",
               in_ready[0], out_valid[0], sum_o[0]);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nfail++;
      $display("FAIL aborted_result: out_valid high %0d cycles required 0", seen);
    end
    run_op(0, 8'h12, 8'h34, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_exhaustive();
    for (int d = 2; d < 5; d++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          for (int cv = 0; cv < 2; cv++) begin
            run_op(d, 8'(av), 8'(bv), 1'(cv), $urandom_range(0, 2));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
